// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared enums and size helpers for the multi-cycle RV32I sequencer
//
// Purpose: opcode, ALU, memory, PC and write-back select encodings used by the
// sequencer and its decoder, plus the sequencer state and memory address select.
// Ports: none (package).

package mc_ctrl_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_OP     = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111
  } opcode_t;

  // Branch funct3 encodings.
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [3:0] {
    ALU_OP_ADD,
    ALU_OP_SUB,
    ALU_OP_SLL,
    ALU_OP_SLT,
    ALU_OP_SLTU,
    ALU_OP_XOR,
    ALU_OP_SRL,
    ALU_OP_SRA,
    ALU_OP_OR,
    ALU_OP_AND,
    ALU_OP_COPY_B
  } alu_op_t;

  typedef enum logic {
    ALU_SRC_A_RS1,
    ALU_SRC_A_PC
  } alu_src_a_t;

  typedef enum logic {
    ALU_SRC_B_RS2,
    ALU_SRC_B_IMM
  } alu_src_b_t;

  typedef enum logic [2:0] {
    MEM_READ_NONE,
    MEM_READ_BYTE,
    MEM_READ_HALF,
    MEM_READ_WORD,
    MEM_READ_BYTE_U,
    MEM_READ_HALF_U
  } mem_read_t;

  typedef enum logic [1:0] {
    MEM_WRITE_NONE,
    MEM_WRITE_BYTE,
    MEM_WRITE_HALF,
    MEM_WRITE_WORD
  } mem_write_t;

  typedef enum logic {
    PC_SRC_PC4,
    PC_SRC_ALU
  } pc_src_t;

  typedef enum logic [1:0] {
    REG_WB_SRC_ALU,
    REG_WB_SRC_MEM,
    REG_WB_SRC_PC4
  } reg_wb_src_t;

  typedef enum logic {
    MEM_ADDR_PC,
    MEM_ADDR_ALU
  } mem_addr_src_t;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_BRTGT,
    S_WB,
    S_HALT
  } mc_state_t;

  function automatic mem_read_t load_size(input logic [2:0] f3);
    case (f3)
      3'b000:  return MEM_READ_BYTE;
      3'b001:  return MEM_READ_HALF;
      3'b010:  return MEM_READ_WORD;
      3'b100:  return MEM_READ_BYTE_U;
      3'b101:  return MEM_READ_HALF_U;
      default: return MEM_READ_NONE;
    endcase
  endfunction

  function automatic mem_write_t store_size(input logic [2:0] f3);
    case (f3)
      3'b000:  return MEM_WRITE_BYTE;
      3'b001:  return MEM_WRITE_HALF;
      3'b010:  return MEM_WRITE_WORD;
      default: return MEM_WRITE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_dec.sv
// rtl/mc_ctrl_dec.sv - combinational instruction checks for the multi-cycle sequencer
//
// Purpose: legality check, EXEC-state ALU control mapping and branch condition.
// Ports:
//   opcode/funct3/funct7            in   IR fields
//   alu_zero/alu_less/alu_uless     in   ALU compare flags
//   illegal                         out  instruction is not a supported RV32I encoding
//   alu_op/alu_src_a/alu_src_b      out  ALU controls for the EXEC state
//   br_take                         out  branch condition for the current funct3

module mc_ctrl_dec import mc_ctrl_pkg::*; (
  input  opcode_t    opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       alu_zero,
  input  logic       alu_less,
  input  logic       alu_uless,
  output logic       illegal,
  output alu_op_t    alu_op,
  output alu_src_a_t alu_src_a,
  output alu_src_b_t alu_src_b,
  output logic       br_take
);

  // Only funct7[5] distinguishes the supported encodings.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  logic   alt;
  alu_op_t arith_op;

  assign alt = funct7[5];

  // Shared OP / OP-IMM mapping; SUB only exists in the register form.
  always_comb begin
    arith_op = ALU_OP_ADD;
    case (funct3)
      3'b000:  arith_op = (opcode == OP_OP && alt) ? ALU_OP_SUB : ALU_OP_ADD;
      3'b001:  arith_op = ALU_OP_SLL;
      3'b010:  arith_op = ALU_OP_SLT;
      3'b011:  arith_op = ALU_OP_SLTU;
      3'b100:  arith_op = ALU_OP_XOR;
      3'b101:  arith_op = alt ? ALU_OP_SRA : ALU_OP_SRL;
      3'b110:  arith_op = ALU_OP_OR;
      default: arith_op = ALU_OP_AND;
    endcase
  end

  always_comb begin
    illegal   = 1'b0;
    alu_op    = ALU_OP_ADD;
    alu_src_a = ALU_SRC_A_RS1;
    alu_src_b = ALU_SRC_B_RS2;
    case (opcode)
      OP_LOAD: begin
        illegal   = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        alu_src_b = ALU_SRC_B_IMM;
      end
      OP_STORE: begin
        illegal   = (funct3 > 3'b010);
        alu_src_b = ALU_SRC_B_IMM;
      end
      OP_JALR: begin
        alu_src_b = ALU_SRC_B_IMM;
      end
      OP_BRANCH: begin
        illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
        alu_op  = ALU_OP_SUB;
      end
      OP_IMM: begin
        illegal   = (funct3 == 3'b001) && alt;
        alu_op    = arith_op;
        alu_src_b = ALU_SRC_B_IMM;
      end
      OP_OP: begin
        illegal = alt && (funct3 != 3'b000) && (funct3 != 3'b101);
        alu_op  = arith_op;
      end
      OP_AUIPC, OP_JAL: begin
        alu_src_a = ALU_SRC_A_PC;
        alu_src_b = ALU_SRC_B_IMM;
      end
      OP_LUI: begin
        alu_op    = ALU_OP_COPY_B;
        alu_src_b = ALU_SRC_B_IMM;
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    br_take = 1'b0;
    case (funct3)
      F3_BEQ:  br_take = alu_zero;
      F3_BNE:  br_take = !alu_zero;
      F3_BLT:  br_take = alu_less;
      F3_BGE:  br_take = !alu_less;
      F3_BLTU: br_take = alu_uless;
      F3_BGEU: br_take = !alu_uless;
      default: br_take = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle RV32I sequencer sharing one memory port for fetch and load/store
//
// Purpose: steps each instruction through FETCH/DECODE/EXEC/(MEM|BRTGT)/WB and
// drives ALU, register-file, PC, IR and memory-request controls.
// Optional feature macro: MC_CTRL_PERF_EN (performance counters; tied to 0 when undefined).
// Ports:
//   clk, rst                        in   clock, synchronous active-high reset
//   opcode/funct3/funct7            in   IR fields
//   alu_zero/alu_less/alu_uless     in   ALU compare flags
//   mem_ready                       in   pending memory request completes this cycle
//   mem_req/mem_addr_src            out  memory request and address select
//   mem_read/mem_write              out  access size
//   ir_write/pc_write/pc_src        out  IR latch, PC update and PC source
//   alu_src_a/alu_src_b/alu_op      out  ALU controls
//   reg_write/reg_wb_src            out  register-file write enable and source
//   illegal/bus_err                 out  sticky error flags (held in S_HALT)
//   state                           out  debug view of the state register
//   cycle_cnt/instret_cnt           out  performance counters

module mc_ctrl import mc_ctrl_pkg::*; #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  opcode_t          opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             alu_zero,
  input  logic             alu_less,
  input  logic             alu_uless,
  input  logic             mem_ready,
  output logic             mem_req,
  output mem_addr_src_t    mem_addr_src,
  output mem_read_t        mem_read,
  output mem_write_t       mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output pc_src_t          pc_src,
  output alu_src_a_t       alu_src_a,
  output alu_src_b_t       alu_src_b,
  output alu_op_t          alu_op,
  output logic             reg_write,
  output reg_wb_src_t      reg_wb_src,
  output logic             illegal,
  output logic             bus_err,
  output mc_state_t        state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  mc_state_t   state_q, state_d;
  logic        take_q;
  logic [31:0] tmo_cnt;
  logic        illegal_q, bus_err_q;
  logic        set_illegal, set_bus_err;

  logic        dec_illegal, dec_take;
  alu_op_t     dec_alu_op;
  alu_src_a_t  dec_src_a;
  alu_src_b_t  dec_src_b;

  mc_ctrl_dec u_dec (
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .alu_zero  (alu_zero),
    .alu_less  (alu_less),
    .alu_uless (alu_uless),
    .illegal   (dec_illegal),
    .alu_op    (dec_alu_op),
    .alu_src_a (dec_src_a),
    .alu_src_b (dec_src_b),
    .br_take   (dec_take)
  );

  // A memory-phase cycle that does not complete counts towards the timeout.
  // The limit is hit on the waiting cycle that would bring the count to
  // TIMEOUT_CYCLES, so a mem_ready on that cycle still completes normally.
  logic waiting, tmo_hit;
  assign waiting = (state_q == S_FETCH || state_q == S_MEM) && !mem_ready;
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && waiting && (tmo_cnt + 32'd1 == TIMEOUT_CYCLES);

  always_comb begin
    state_d      = state_q;
    set_illegal  = 1'b0;
    set_bus_err  = 1'b0;
    mem_req      = 1'b0;
    mem_addr_src = MEM_ADDR_PC;
    mem_read     = MEM_READ_NONE;
    mem_write    = MEM_WRITE_NONE;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_SRC_PC4;
    alu_src_a    = ALU_SRC_A_RS1;
    alu_src_b    = ALU_SRC_B_RS2;
    alu_op       = ALU_OP_ADD;
    reg_write    = 1'b0;
    reg_wb_src   = REG_WB_SRC_ALU;
    // Outputs stay quiet while rst is high so an abandoned request drops at once.
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req      = 1'b1;
          mem_addr_src = MEM_ADDR_PC;
          mem_read     = MEM_READ_WORD;
          if (mem_ready) begin
            ir_write = 1'b1;
            state_d  = S_DECODE;
          end else if (tmo_hit) begin
            set_bus_err = 1'b1;
            state_d     = S_HALT;
          end
        end
        S_DECODE: begin
          if (dec_illegal) begin
            set_illegal = 1'b1;
            state_d     = S_HALT;
          end else begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          alu_op    = dec_alu_op;
          alu_src_a = dec_src_a;
          alu_src_b = dec_src_b;
          case (opcode)
            OP_LOAD, OP_STORE: state_d = S_MEM;
            OP_BRANCH:         state_d = S_BRTGT;
            default:           state_d = S_WB;
          endcase
        end
        S_BRTGT: begin
          alu_src_a = ALU_SRC_A_PC;
          alu_src_b = ALU_SRC_B_IMM;
          alu_op    = ALU_OP_ADD;
          state_d   = S_WB;
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_addr_src = MEM_ADDR_ALU;
          if (opcode == OP_STORE) begin
            mem_write = store_size(funct3);
          end else begin
            mem_read = load_size(funct3);
          end
          if (mem_ready) begin
            state_d = S_WB;
          end else if (tmo_hit) begin
            set_bus_err = 1'b1;
            state_d     = S_HALT;
          end
        end
        S_WB: begin
          pc_write = 1'b1;
          if (opcode == OP_JAL || opcode == OP_JALR || (opcode == OP_BRANCH && take_q)) begin
            pc_src = PC_SRC_ALU;
          end
          reg_write = !(opcode == OP_STORE || opcode == OP_BRANCH);
          if (opcode == OP_LOAD) begin
            reg_wb_src = REG_WB_SRC_MEM;
          end else if (opcode == OP_JAL || opcode == OP_JALR) begin
            reg_wb_src = REG_WB_SRC_PC4;
          end
          state_d = S_FETCH;
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_HALT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      take_q    <= 1'b0;
      tmo_cnt   <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_EXEC && opcode == OP_BRANCH) begin
        take_q <= dec_take;
      end
      if (waiting && !tmo_hit) begin
        tmo_cnt <= tmo_cnt + 32'd1;
      end else begin
        tmo_cnt <= '0;
      end
      if (set_illegal) illegal_q <= 1'b1;
      if (set_bus_err) bus_err_q <= 1'b1;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;

`ifdef MC_CTRL_PERF_EN
  logic [CNT_W-1:0] cyc_q, ret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if (state_q != S_HALT) cyc_q <= cyc_q + CNT_W'(1);
      if (state_q == S_WB)   ret_q <= ret_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = cyc_q;
  assign instret_cnt = ret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - self-checking bench for the multi-cycle sequencer

module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  localparam int unsigned TMO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  opcode_t       opcode;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic          alu_zero, alu_less, alu_uless, mem_ready;
  logic          mem_req, ir_write, pc_write, reg_write, illegal, bus_err;
  mem_addr_src_t mem_addr_src;
  mem_read_t     mem_read;
  mem_write_t    mem_write;
  pc_src_t       pc_src;
  alu_src_a_t    alu_src_a;
  alu_src_b_t    alu_src_b;
  alu_op_t       alu_op;
  reg_wb_src_t   reg_wb_src;
  mc_state_t     state;
  logic [31:0]   cycle_cnt, instret_cnt;

  mc_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_zero(alu_zero), .alu_less(alu_less), .alu_uless(alu_uless),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_addr_src(mem_addr_src),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .reg_wb_src(reg_wb_src), .illegal(illegal), .bus_err(bus_err),
    .state(state), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    mc_state_t     st;
    logic          req, irw, pcw, rw;
    alu_op_t       aop;
    alu_src_a_t    sa;
    alu_src_b_t    sb;
    pc_src_t       ps;
    reg_wb_src_t   wb;
    mem_read_t     mr;
    mem_write_t    mw;
    mem_addr_src_t mas;
  } obs_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [2:0] flg;   // {zero, less, uless}
    logic       rdy;
    obs_t       exp;
  } vec_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ill;
  } ill_t;

  vec_t tbl[$];
  ill_t itab[$];
  int   checks = 0;
  int   errors = 0;
  logic [6:0] ci_op;
  logic [2:0] ci_f3;
  logic [6:0] ci_f7;

  function automatic obs_t base(input mc_state_t st);
    obs_t o;
    o.st = st; o.req = 1'b0; o.irw = 1'b0; o.pcw = 1'b0; o.rw = 1'b0;
    o.aop = ALU_OP_ADD; o.sa = ALU_SRC_A_RS1; o.sb = ALU_SRC_B_RS2;
    o.ps = PC_SRC_PC4; o.wb = REG_WB_SRC_ALU; o.mr = MEM_READ_NONE;
    o.mw = MEM_WRITE_NONE; o.mas = MEM_ADDR_PC;
    return o;
  endfunction

  function automatic obs_t sample_dut();
    obs_t o;
    o.st = state; o.req = mem_req; o.irw = ir_write; o.pcw = pc_write; o.rw = reg_write;
    o.aop = alu_op; o.sa = alu_src_a; o.sb = alu_src_b; o.ps = pc_src; o.wb = reg_wb_src;
    o.mr = mem_read; o.mw = mem_write; o.mas = mem_addr_src;
    return o;
  endfunction

  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    ci_op = op; ci_f3 = f3; ci_f7 = f7;
  endtask

  task automatic push(input logic [2:0] flg, input logic rdy, input obs_t e);
    vec_t v;
    v.op = ci_op; v.f3 = ci_f3; v.f7 = ci_f7; v.flg = flg; v.rdy = rdy; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic p_fetch(input logic rdy);
    obs_t e = base(S_FETCH);
    e.req = 1'b1; e.irw = rdy; e.mr = MEM_READ_WORD; e.mas = MEM_ADDR_PC;
    push(3'b000, rdy, e);
  endtask

  task automatic p_dec();
    push(3'b000, 1'b0, base(S_DECODE));
  endtask

  task automatic p_exec(input logic [2:0] flg, input alu_op_t aop, input alu_src_a_t sa, input alu_src_b_t sb);
    obs_t e = base(S_EXEC);
    e.aop = aop; e.sa = sa; e.sb = sb;
    push(flg, 1'b0, e);
  endtask

  task automatic p_brtgt();
    obs_t e = base(S_BRTGT);
    e.sa = ALU_SRC_A_PC; e.sb = ALU_SRC_B_IMM;
    push(3'b000, 1'b0, e);
  endtask

  task automatic p_mem(input logic rdy, input mem_read_t mr, input mem_write_t mw);
    obs_t e = base(S_MEM);
    e.req = 1'b1; e.mas = MEM_ADDR_ALU; e.mr = mr; e.mw = mw;
    push(3'b000, rdy, e);
  endtask

  task automatic p_wb(input pc_src_t ps, input reg_wb_src_t wb, input logic rw);
    obs_t e = base(S_WB);
    e.pcw = 1'b1; e.ps = ps; e.wb = wb; e.rw = rw;
    push(3'b000, 1'b0, e);
  endtask

  task automatic check_obs(input string nm, input obs_t e);
    obs_t a = sample_dut();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, a, e);
    end
  endtask

  task automatic check_val(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, a, e);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [2:0] flg, input logic rdy);
    opcode = opcode_t'(op); funct3 = f3; funct7 = f7;
    {alu_zero, alu_less, alu_uless} = flg;
    mem_ready = rdy;
  endtask

  // Entered and left just after a falling edge; one rising edge with rst high.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    // addi x1,x0,5
    instr(7'b0010011, 3'b000, 7'h00);
    p_fetch(1); p_dec(); p_exec(0, ALU_OP_ADD, ALU_SRC_A_RS1, ALU_SRC_B_IMM); p_wb(PC_SRC_PC4, REG_WB_SRC_ALU, 1);
    // sub with one fetch wait
    instr(7'b0110011, 3'b000, 7'h20);
    p_fetch(0); p_fetch(1); p_dec(); p_exec(0, ALU_OP_SUB, ALU_SRC_A_RS1, ALU_SRC_B_RS2); p_wb(PC_SRC_PC4, REG_WB_SRC_ALU, 1);
    // srai
    instr(7'b0010011, 3'b101, 7'h20);
    p_fetch(1); p_dec(); p_exec(0, ALU_OP_SRA, ALU_SRC_A_RS1, ALU_SRC_B_IMM); p_wb(PC_SRC_PC4, REG_WB_SRC_ALU, 1);
    // lw, three memory wait cycles
    instr(7'b0000011, 3'b010, 7'h00);
    p_fetch(1); p_dec(); p_exec(0, ALU_OP_ADD, ALU_SRC_A_RS1, ALU_SRC_B_IMM);
    p_mem(0, MEM_READ_WORD, MEM_WRITE_NONE); p_mem(0, MEM_READ_WORD, MEM_WRITE_NONE);
    p_mem(0, MEM_READ_WORD, MEM_WRITE_NONE); p_mem(1, MEM_READ_WORD, MEM_WRITE_NONE);
    p_wb(PC_SRC_PC4, REG_WB_SRC_MEM, 1);
    // sw
    instr(7'b0100011, 3'b010, 7'h00);
    p_fetch(1); p_dec(); p_exec(0, ALU_OP_ADD, ALU_SRC_A_RS1, ALU_SRC_B_IMM);
    p_mem(1, MEM_READ_NONE, MEM_WRITE_WORD); p_wb(PC_SRC_PC4, REG_WB_SRC_ALU, 0);
    // lbu
    instr(7'b0000011, 3'b100, 7'h00);
    p_fetch(1); p_dec(); p_exec(0, ALU_OP_ADD, ALU_SRC_A_RS1, ALU_SRC_B_IMM);
    p_mem(1, MEM_READ_BYTE_U, MEM_WRITE_NONE); p_wb(PC_SRC_PC4, REG_WB_SRC_MEM, 1);
    // beq taken (zero=1 only during EXEC)
    instr(7'b1100011, 3'b000, 7'h00);
    p_fetch(1); p_dec(); p_exec(3'b100, ALU_OP_SUB, ALU_SRC_A_RS1, ALU_SRC_B_RS2); p_brtgt(); p_wb(PC_SRC_ALU, REG_WB_SRC_ALU, 0);
    // beq not taken
    p_fetch(1); p_dec(); p_exec(3'b000, ALU_OP_SUB, ALU_SRC_A_RS1, ALU_SRC_B_RS2); p_brtgt(); p_wb(PC_SRC_PC4, REG_WB_SRC_ALU, 0);
    // bltu taken
    instr(7'b1100011, 3'b110, 7'h00);
    p_fetch(1); p_dec(); p_exec(3'b001, ALU_OP_SUB, ALU_SRC_A_RS1, ALU_SRC_B_RS2); p_brtgt(); p_wb(PC_SRC_ALU, REG_WB_SRC_ALU, 0);
    // bge with less=1: not taken
    instr(7'b1100011, 3'b101, 7'h00);
    p_fetch(1); p_dec(); p_exec(3'b010, ALU_OP_SUB, ALU_SRC_A_RS1, ALU_SRC_B_RS2); p_brtgt(); p_wb(PC_SRC_PC4, REG_WB_SRC_ALU, 0);
    // jal
    instr(7'b1101111, 3'b000, 7'h00);
    p_fetch(1); p_dec(); p_exec(0, ALU_OP_ADD, ALU_SRC_A_PC, ALU_SRC_B_IMM); p_wb(PC_SRC_ALU, REG_WB_SRC_PC4, 1);
    // jalr
    instr(7'b1100111, 3'b000, 7'h00);
    p_fetch(1); p_dec(); p_exec(0, ALU_OP_ADD, ALU_SRC_A_RS1, ALU_SRC_B_IMM); p_wb(PC_SRC_ALU, REG_WB_SRC_PC4, 1);
    // lui
    instr(7'b0110111, 3'b000, 7'h00);
    p_fetch(1); p_dec(); p_exec(0, ALU_OP_COPY_B, ALU_SRC_A_RS1, ALU_SRC_B_IMM); p_wb(PC_SRC_PC4, REG_WB_SRC_ALU, 1);
    // auipc
    instr(7'b0010111, 3'b000, 7'h00);
    p_fetch(1); p_dec(); p_exec(0, ALU_OP_ADD, ALU_SRC_A_PC, ALU_SRC_B_IMM); p_wb(PC_SRC_PC4, REG_WB_SRC_ALU, 1);

    itab.push_back('{7'b0000011, 3'b011, 7'h00, 1'b1});
    itab.push_back('{7'b0000011, 3'b110, 7'h00, 1'b1});
    itab.push_back('{7'b0100011, 3'b011, 7'h00, 1'b1});
    itab.push_back('{7'b1100011, 3'b010, 7'h00, 1'b1});
    itab.push_back('{7'b0110011, 3'b001, 7'h20, 1'b1});
    itab.push_back('{7'b0010011, 3'b001, 7'h20, 1'b1});
    itab.push_back('{7'b1111111, 3'b000, 7'h00, 1'b1});
    itab.push_back('{7'b0000011, 3'b101, 7'h00, 1'b0});
    itab.push_back('{7'b0100011, 3'b010, 7'h00, 1'b0});
    itab.push_back('{7'b1100011, 3'b111, 7'h00, 1'b0});
    itab.push_back('{7'b0110011, 3'b101, 7'h20, 1'b0});
    itab.push_back('{7'b0010011, 3'b101, 7'h20, 1'b0});

    // Reset state
    drive(7'b0010011, 3'b000, 7'h00, 3'b000, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    check_obs("reset_outputs", base(S_FETCH));
    check_val("reset_illegal", {31'd0, illegal}, 32'd0);
    check_val("reset_bus_err", {31'd0, bus_err}, 32'd0);
    check_val("reset_cycle_cnt", cycle_cnt, 32'd0);
    check_val("reset_instret_cnt", instret_cnt, 32'd0);
    rst = 1'b0;

    // Cycle-by-cycle instruction table
    foreach (tbl[i]) begin
      drive(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].flg, tbl[i].rdy);
      #1;
      check_obs($sformatf("row%0d", i), tbl[i].exp);
      @(negedge clk);
    end
    check_val("table_no_errflags", {30'd0, illegal, bus_err}, 32'd0);

    // Illegal opcode 0: DECODE, then HALT held for 20 cycles
    do_reset();
    drive(7'b0000000, 3'b000, 7'h00, 3'b000, 1'b1);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check_val("ill0_decode", {29'd0, state}, {29'd0, S_DECODE});
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      mem_ready = k[0];
      #1;
      check_val($sformatf("ill0_halt%0d", k),
                {28'd0, state == S_HALT, pc_write, mem_req, illegal}, 32'b1001);
    end

    // Legality table: fetch, decode, then HALT or EXEC
    foreach (itab[k]) begin
      do_reset();
      drive(itab[k].op, itab[k].f3, itab[k].f7, 3'b000, 1'b1);
      @(negedge clk);
      mem_ready = 1'b0;
      @(negedge clk);
      #1;
      check_val($sformatf("legal%0d", k), {29'd0, state, illegal},
                {29'd0, itab[k].ill ? S_HALT : S_EXEC, itab[k].ill});
    end

    // Fetch timeout: eight waiting cycles, then HALT with bus_err
    do_reset();
    drive(7'b0010011, 3'b000, 7'h00, 3'b000, 1'b0);
    for (int k = 0; k < 8; k++) begin
      #1;
      check_val($sformatf("tmo_wait%0d", k), {29'd0, state, mem_req}, {29'd0, S_FETCH, 1'b1});
      @(negedge clk);
    end
    #1;
    check_val("tmo_halt", {28'd0, state, mem_req}, {28'd0, S_HALT, 1'b0});
    check_val("tmo_bus_err", {30'd0, bus_err, illegal}, 32'b10);

    // mem_ready on the limit cycle wins
    do_reset();
    check_val("tmo_reset_clears", {31'd0, bus_err}, 32'd0);
    repeat (7) @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check_val("tmo_limit_ready", {28'd0, state, bus_err}, {28'd0, S_DECODE, 1'b0});

    // Counter clears between fetch and memory phases (5 + 5 waits)
    do_reset();
    drive(7'b0000011, 3'b010, 7'h00, 3'b000, 1'b0);
    repeat (5) @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    repeat (5) @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check_val("tmo_phase_clear", {28'd0, state, bus_err}, {28'd0, S_WB, 1'b0});

    // Reset during a stalled sw
    do_reset();
    drive(7'b0100011, 3'b010, 7'h00, 3'b000, 1'b1);
    @(negedge clk);
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_val("sw_mem_stall", {27'd0, state, mem_req, mem_write},
              {27'd0, S_MEM, 1'b1, MEM_WRITE_WORD});
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_val("rst_drops_req", {27'd0, state, mem_req, mem_write},
              {27'd0, S_FETCH, 1'b0, MEM_WRITE_NONE});
    rst = 1'b0;
    #1;
    check_val("rst_release", {28'd0, state, mem_req}, {28'd0, S_FETCH, 1'b1});

    // Three addi from reset
    do_reset();
    drive(7'b0010011, 3'b000, 7'h00, 3'b000, 1'b1);
    repeat (12) @(negedge clk);
    #1;
    check_val("perf_state", {29'd0, state}, {29'd0, S_FETCH});
`ifdef MC_CTRL_PERF_EN
    check_val("perf_cycle_cnt", cycle_cnt, 32'd12);
    check_val("perf_instret_cnt", instret_cnt, 32'd3);
`else
    check_val("perf_cycle_cnt", cycle_cnt, 32'd0);
    check_val("perf_instret_cnt", instret_cnt, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle sequencer for the RV32I datapath. It shares one unified memory port between instruction fetch and load/store, and steps each instruction through FETCH/DECODE/EXEC/(MEM|BRTGT)/WB. It drives the same ALU, register-file and memory controls as the single-cycle decoder, plus the multi-cycle strobes pc_write and ir_write and the memory request handshake. It sits between the IR fields, the ALU flags and the memory port.

Parameters:
TIMEOUT_CYCLES, 64, number of consecutive cycles mem_req may wait without mem_ready before a bus error; 0 disables the timeout.
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
opcode  in  opcode_t  from IR
funct3  in  3  from IR
funct7  in  7  from IR
alu_zero / alu_less / alu_uless  in  1 each  ALU compare flags
mem_ready  in  1  memory completes the pending request this cycle
mem_req  out  1  memory request
mem_addr_src  out  mem_addr_src_t  0 = PC, 1 = alu_out register
mem_read  out  mem_read_t  read size
mem_write  out  mem_write_t  write size
ir_write  out  1  latch IR and old_pc
pc_write  out  1  update PC
pc_src  out  pc_src_t  PC4 or ALU (alu_out register)
alu_src_a  out  alu_src_a_t
alu_src_b  out  alu_src_b_t
alu_op  out  alu_op_t
reg_write  out  1  register-file write enable
reg_wb_src  out  reg_wb_src_t  write-back source
illegal  out  1  sticky illegal-instruction flag
bus_err  out  1  sticky memory-timeout flag
state  out  mc_state_t  debug view of the state register
cycle_cnt  out  CNT_W  performance counter
instret_cnt  out  CNT_W  performance counter

Behaviour:
- Reset (while rst high): state=S_FETCH, take_q=0, timeout counter=0, illegal=0, bus_err=0, counters=0.
- Output defaults every cycle: all strobes 0, mem_read/mem_write=NONE, ALU_SRC_A_RS1, ALU_SRC_B_RS2, ALU_OP_ADD, PC_SRC_PC4, REG_WB_SRC_ALU.
- S_FETCH:
  - Drives mem_req=1, mem_addr_src=PC, mem_read=WORD.
  - On mem_ready: ir_write=1 (Mealy) and go to S_DECODE.
  - Otherwise stay in S_FETCH.
- S_DECODE:
  - Register file is read; no strobes.
  - If the instruction is illegal, go to S_HALT and set illegal. Otherwise go to S_EXEC.
  - Illegal means: unknown opcode; load funct3 in {011,110,111}; store funct3>010; branch funct3 in {010,011}; OP with an undefined {funct7[5],funct3} combination; SLLI with funct7[5]=1.
- S_EXEC:
  - ALU controls follow the single-cycle decode mapping: LOAD/STORE/JALR use RS1+IMM ADD; OP-IMM and OP use their ops; AUIPC and JAL use PC+IMM ADD; LUI uses COPY_B; BRANCH uses RS1-RS2 SUB.
  - alu_out latches the ALU result.
  - For BRANCH, take_q latches the condition (BEQ/BNE/BLT/BGE/BLTU/BGEU on zero/less/uless).
  - Next state: LOAD/STORE go to S_MEM; BRANCH goes to S_BRTGT; all others go to S_WB.
- S_BRTGT: alu_src_a=PC, alu_src_b=IMM, ADD (target into alu_out), then go to S_WB.
- S_MEM:
  - Drives mem_req=1, mem_addr_src=ALU, mem_read/mem_write sized per funct3.
  - mem_req and size are held stable until mem_ready; a request is never withdrawn except by rst or timeout.
  - On mem_ready go to S_WB; load data is latched by the datapath.
- S_WB:
  - pc_write=1 exactly once per instruction.
  - pc_src=ALU for JAL, JALR and taken branches; PC4 otherwise.
  - reg_write=1 except for STORE and BRANCH.
  - wb_src: MEM for LOAD, PC4 for JAL/JALR, ALU otherwise.
  - Next state is S_FETCH.
- Latency with zero-wait memory: ALU/LUI/AUIPC/JAL/JALR take 4 cycles; LOAD/STORE/BRANCH take 5. Each memory wait cycle adds 1.
- Timeout:
  - The counter increments while in S_FETCH/S_MEM with mem_req=1 and mem_ready=0, and clears on mem_ready or on a state change.
  - When the counter reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES≠0): go to S_HALT and set bus_err.
  - mem_ready in the same cycle as the limit wins; no error is raised.
- S_HALT: all strobes 0; the state is held until rst.
- Reset mid-operation: the request is dropped next cycle; memory must tolerate an abandoned request.

Optional Feature:
MC_CTRL_PERF_EN:
- Defined: cycle_cnt increments every non-halt cycle; instret_cnt increments on each S_WB. Both wrap modulo 2^CNT_W.
- Undefined: both ports are tied to 0 and no counter registers are inferred.

Decomposition:
- typepkg gains mc_state_t (S_FETCH, S_DECODE, S_EXEC, S_MEM, S_BRTGT, S_WB, S_HALT) and mem_addr_src_t.
- Existing opcode, funct3, ALU and mem enums are reused.
- One combinational sub-module, mc_ctrl_dec, provides the illegal check, the EXEC-state ALU mapping and the branch condition.

Test Plan:
- addi x1,x0,5 with immediate mem_ready → states F,D,E,W. ir_write in cycle 0; EXEC drives ALU_OP_ADD/SRC_B_IMM; cycle 3 has reg_write=1, pc_write=1, pc_src=PC4.
- lw with mem_ready delayed 3 cycles in MEM → mem_req high 4 cycles with mem_read=WORD and addr_src=ALU stable; WB reg_write=1, wb_src=MEM; 8 cycles total.
- beq with alu_zero=1 → BRTGT drives SRC_A_PC; WB pc_src=ALU, reg_write=0. With alu_zero=0 → WB pc_src=PC4.
- Opcode 7'b0000000 → DECODE then S_HALT; illegal=1; no pc_write; held for 20 cycles until rst.
- TIMEOUT_CYCLES=8 with mem_ready never asserted in FETCH → S_HALT after 8 waiting cycles, bus_err=1, mem_req=0.
- rst asserted during MEM of sw with mem_ready=0 → next cycle mem_req=0 and mem_write=NONE. After release, state=S_FETCH. With MC_CTRL_PERF_EN, three addi give instret_cnt=3 and cycle_cnt=12.
